// File: rtl/sin_cos_to_arg_pkg.sv
// Shared types and elaboration-time helpers for the vectoring CORDIC phase
// detector: FSM state encoding, internal guard width and arctangent table.
package sin_cos_to_arg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // x/y carry two guard bits over WIDTH so that folding -2^(WIDTH-1) and the
   // CORDIC gain growth (K < 2) never overflow.
   localparam int GUARD_BITS = 2;

   // Largest number of micro-rotations the table type can hold.
   localparam int MAX_ITER = 32;

   localparam real PI = 3.14159265358979323846;

   typedef logic [31:0] atan_tab_t [0:MAX_ITER-1];

   // A[i] = round(atan(2^-i) * 2^width / (2*pi)); unused entries are zero.
   function automatic atan_tab_t atan_lut(input int width, input int iter);
      atan_tab_t tab;
      real       scale;
      real       p;
      scale = 1.0;
      for (int k = 0; k < width; k++) scale = scale * 2.0;
      scale = scale / (2.0 * PI);
      p = 1.0;
      for (int k = 0; k < MAX_ITER; k++) begin
         if (k < iter) tab[k] = 32'($rtoi($atan(p) * scale + 0.5));
         else          tab[k] = '0;
         p = p / 2.0;
      end
      return tab;
   endfunction

endpackage

// File: rtl/sin_cos_to_arg.sv
// Iterative vectoring-mode CORDIC: converts a signed (cos, sin) pair into an
// unsigned full-circle angle (2^WIDTH = 2*pi) and the gain-scaled magnitude.
// One sample in flight at a time; valid/ready handshake on both sides.
module sin_cos_to_arg
   import sin_cos_to_arg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clkena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sin,
   input  logic [WIDTH-1:0] cos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] arg,
   output logic [WIDTH:0]   mag
);

   localparam int        XW    = WIDTH + GUARD_BITS;
   localparam logic [4:0] LAST = 5'(ITER - 1);
   localparam atan_tab_t A_TAB = atan_lut(WIDTH, ITER);

   state_t                  state;
   state_t                  state_nxt;
   logic [4:0]              i;
   logic signed [XW-1:0]    x;
   logic signed [XW-1:0]    y;
   logic [WIDTH-1:0]        z;
   logic                    zero;

   logic signed [XW-1:0]    cos_x;
   logic signed [XW-1:0]    sin_x;
   logic signed [XW-1:0]    x_in;
   logic signed [XW-1:0]    y_in;
   logic [WIDTH-1:0]        z_in;
   logic [WIDTH-1:0]        a_cur;
   logic [31:0]             a_word;

   assign a_word = A_TAB[i];
   assign a_cur  = a_word[WIDTH-1:0];

   // Quadrant fold: move left-half-plane vectors to the right half and preload pi.
   always_comb begin
      cos_x = signed'({{GUARD_BITS{cos[WIDTH-1]}}, cos});
      sin_x = signed'({{GUARD_BITS{sin[WIDTH-1]}}, sin});
      x_in  = cos_x;
      y_in  = sin_x;
      z_in  = '0;
      if (cos[WIDTH-1]) begin
         x_in = -cos_x;
         y_in = -sin_x;
         z_in = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; a low clkena holds the current state.
   always_comb begin
      state_nxt = state;
      if (clkena) begin
         case (state)
            IDLE:    if (in_valid)  state_nxt = ROTATE;
            ROTATE:  if (i == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: capture the folded sample, then one micro-rotation per enabled edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i    <= '0;
         x    <= '0;
         y    <= '0;
         z    <= '0;
         zero <= 1'b0;
      end else if (clkena) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x    <= x_in;
                  y    <= y_in;
                  z    <= z_in;
                  i    <= '0;
                  zero <= (cos == '0) && (sin == '0);
               end
            end
            ROTATE: begin
               if (!y[XW-1]) begin
                  x <= x + (y >>> i);
                  y <= y - (x >>> i);
               end else begin
                  x <= x - (y >>> i);
                  y <= y + (x >>> i);
               end
               // A zero vector would otherwise accumulate the whole table.
               if (!zero) z <= y[XW-1] ? (z - a_cur) : (z + a_cur);
               if (i != LAST) i <= i + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign arg       = z;
   assign mag       = x[WIDTH:0];

endmodule

// File: tb/tb_sin_cos_to_arg.sv
// Directed bench for sin_cos_to_arg (WIDTH=16, ITER=16): reset, cardinal
// points, negative corner, round trip, backpressure, clkena and mid-reset.
module tb_sin_cos_to_arg;

   logic               clk;
   logic               reset;
   logic               clkena;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] sin_i;
   logic signed [15:0] cos_i;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        arg;
   logic [16:0]        mag;

   int assertions = 0;
   int failures   = 0;
   logic tog = 1'b0;

   localparam real TB_PI = 3.14159265358979323846;

   sin_cos_to_arg #(.WIDTH(16), .ITER(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .clkena    (clkena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sin       (sin_i),
      .cos       (cos_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .arg       (arg),
      .mag       (mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // clkena driver: constant 1, or alternating every edge when tog is set
   initial begin
      clkena = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (tog) clkena = ~clkena;
         else     clkena = 1'b1;
      end
   end

   function automatic int adiff(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] d;
      d = a - b;
      return (d > 16'd32768) ? (65536 - int'(d)) : int'(d);
   endfunction

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic start_and_wait(input logic signed [15:0] c, input logic signed [15:0] s,
                                 output int lat);
      int n;
      cos_i    = c;
      sin_i    = s;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (in_ready && n < 100);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      assertions++;
      if (!out_valid) begin
         failures++;
         $display("FAIL handshake_timeout: out_valid=%0b in_ready=%0b required out_valid=1", out_valid, in_ready);
      end
   endtask

   task automatic pop();
      int n;
      n = 0;
      out_ready = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (out_valid && n < 100);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      assertions++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || arg !== 16'd0 || mag !== 17'd0) begin
         failures++;
         $display("FAIL reset_state: out_valid=%0b in_ready=%0b arg=%0d mag=%0d required 0 1 0 0",
                  out_valid, in_ready, arg, mag);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_cardinal();
      logic signed [15:0] cv [4] = '{16'sd16384, 16'sd0, -16'sd16384, 16'sd0};
      logic signed [15:0] sv [4] = '{16'sd0, 16'sd16384, 16'sd0, -16'sd16384};
      logic [15:0]        ev [4] = '{16'd0, 16'd16384, 16'd32768, 16'd49152};
      int lat;
      for (int k = 0; k < 4; k++) begin
         start_and_wait(cv[k], sv[k], lat);
         assertions++;
         if (adiff(arg, ev[k]) > 4) begin
            failures++;
            $display("FAIL cardinal_arg[%0d]: arg=%0d required %0d +-4", k, arg, ev[k]);
         end
         assertions++;
         if (lat != 16) begin
            failures++;
            $display("FAIL cardinal_latency[%0d]: edges=%0d required 16", k, lat);
         end
         if (k == 0) begin
            assertions++;
            if (iabs(int'(mag) - 26981) > 4) begin
               failures++;
               $display("FAIL cardinal_mag: mag=%0d required 26981 +-4", mag);
            end
         end
         pop();
      end
   endtask

   task automatic test_corner();
      int lat;
      start_and_wait(-16'sd32768, -16'sd32768, lat);
      assertions++;
      if (adiff(arg, 16'd40960) > 4) begin
         failures++;
         $display("FAIL corner_arg: arg=%0d required 40960 +-4", arg);
      end
      assertions++;
      if (iabs(int'(mag) - 76313) > 8) begin
         failures++;
         $display("FAIL corner_mag: mag=%0d required 76313 +-8", mag);
      end
      pop();
   endtask

   task automatic test_round_trip();
      int          lat;
      int          a;
      int          extra [4] = '{65535, 0, 1, 65534};
      logic [15:0] ea;
      real         ph;
      for (int k = 0; k < 47; k++) begin
         a  = (k < 43) ? (k * 1531) : extra[k-43];
         ea = 16'(a);
         ph = 2.0 * TB_PI * real'(a) / 65536.0;
         start_and_wait(16'(rnd(32767.0 * $cos(ph))), 16'(rnd(32767.0 * $sin(ph))), lat);
         assertions++;
         if (adiff(arg, ea) > 4) begin
            failures++;
            $display("FAIL round_trip[%0d]: arg=%0d required %0d +-4", k, arg, ea);
         end
         pop();
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [15:0] a0;
      logic [16:0] m0;
      start_and_wait(16'sd10000, 16'sd10000, lat);
      a0 = arg;
      m0 = mag;
      assertions++;
      if (adiff(a0, 16'd8192) > 4) begin
         failures++;
         $display("FAIL bp_arg: arg=%0d required 8192 +-4", a0);
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         assertions++;
         if (arg !== a0 || mag !== m0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d]: arg=%0d mag=%0d in_ready=%0b out_valid=%0b required %0d %0d 0 1",
                     c, arg, mag, in_ready, out_valid, a0, m0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      assertions++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_clkena();
      int lat;
      tog = 1'b1;
      start_and_wait(16'sd0, 16'sd16384, lat);
      assertions++;
      if (lat != 32) begin
         failures++;
         $display("FAIL clkena_latency: edges=%0d required 32", lat);
      end
      assertions++;
      if (adiff(arg, 16'd16384) > 4) begin
         failures++;
         $display("FAIL clkena_arg: arg=%0d required 16384 +-4", arg);
      end
      pop();
      tog = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      int lat;
      cos_i    = 16'sd12000;
      sin_i    = 16'sd5000;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (in_ready && n < 100);
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      assertions++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      assertions++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_no_result: out_valid=%0b required 0", out_valid);
      end
      start_and_wait(16'sd0, 16'sd0, lat);
      assertions++;
      if (arg !== 16'd0 || mag !== 17'd0) begin
         failures++;
         $display("FAIL zero_vector: arg=%0d mag=%0d required 0 0", arg, mag);
      end
      pop();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sin_i     = '0;
      cos_i     = '0;
      #1;
      test_reset();
      test_cardinal();
      test_corner();
      test_round_trip();
      test_backpressure();
      test_clkena();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
